lut_bank: RTL

Parametrised bank of N reconfigurable K-input universal gates with a serial configuration port, double-buffered (shadow/active) configuration and a per-cell selectable registered output. It is the sequential successor to the fixed-size combinational universal-gate cells: any K-input boolean function per cell, reconfigurable at run time without glitching live outputs, plus the output-select mux. It sits between the configuration shift interface and the gate I/O pins.

---
 rtl/lut_bank.sv | 103 ++++++++++
 1 files changed

// File: rtl/lut_bank.sv
// lut_bank: bank of N K-input truth-table cells with a serial, double-buffered
// configuration port and a per-cell combinational/registered output select.
module lut_bank #(
  parameter int unsigned K = 2,
  parameter int unsigned N = 4,
  localparam int unsigned TW = 2 ** K,
  localparam int unsigned CW = N * (TW + 1),
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  input  logic          cfg_bit,
  output logic          cfg_ready,
  input  logic          cfg_commit,
  output logic          cfg_loaded,
  input  logic [N*K-1:0] in,
  output logic [N-1:0]  out,
  input  logic [SW-1:0] sel,
  output logic          mux_out
);

  localparam int unsigned CNTW = $clog2(CW + 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CW-1:0]   shadow_q, shadow_d;
  logic [CW-1:0]   active_q, active_d;
  logic [N-1:0]    cell_q, cell_d;
  logic [N-1:0]    f;
  logic [TW-1:0]   tt;

  // State, shadow/active config and registered cell outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      count_q  <= '0;
      shadow_q <= '0;
      active_q <= '0;
      cell_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cell_q   <= cell_d;
    end
  end

  // Config FSM: shift until full, then wait for commit (input ignored while full)
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    active_d = active_q;
    case (state_q)
      EMPTY, SHIFT: begin
        if (cfg_valid) begin
          shadow_d = {shadow_q[CW-2:0], cfg_bit};
          count_d  = count_q + CNTW'(1);
          state_d  = (count_q == CNTW'(CW - 1)) ? FULL : SHIFT;
        end
      end
      FULL: begin
        if (cfg_commit) begin
          active_d = shadow_q;
          count_d  = '0;
          state_d  = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign cfg_ready  = (count_q < CNTW'(CW));
  assign cfg_loaded = (state_q == FULL);

  // Per-cell truth-table lookup and output-mode select
  always_comb begin
    f   = '0;
    out = '0;
    tt  = '0;
    for (int i = 0; i < N; i++) begin
      tt     = active_q[i*(TW+1) +: TW];
      f[i]   = tt[in[i*K +: K]];
      out[i] = active_q[i*(TW+1)+TW] ? cell_q[i] : f[i];
    end
    cell_d = f;
  end

  // Output select; out-of-range select reads as 0
  always_comb begin
    mux_out = 1'b0;
    if (32'(sel) < N) mux_out = out[sel];
  end

endmodule
